// File: rtl/button_debouncer.sv
// Debouncer for a raw mechanical input: synchronizer chain followed by a Moore FSM
// that accepts a level change only after it has been stable for DEBOUNCE_CYCLES cycles.
module button_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   output logic db,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      WAIT_HIGH = 2'b01,
      IDLE_HIGH = 2'b10,
      WAIT_LOW  = 2'b11
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   db_q, busy_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A mismatch on s is checked before the terminal count, so a bounce on the
   // final counting cycle still rejects the change.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         IDLE_LOW: begin
            if (s) state_d = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (!s)                  state_d = IDLE_LOW;
            else if (cnt_q == CNT_LAST) state_d = IDLE_HIGH;
            else                     cnt_d   = cnt_q + CNT_WIDTH'(1);
         end
         IDLE_HIGH: begin
            if (!s) state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (s)                   state_d = IDLE_HIGH;
            else if (cnt_q == CNT_LAST) state_d = IDLE_LOW;
            else                     cnt_d   = cnt_q + CNT_WIDTH'(1);
         end
         default: begin
            state_d = IDLE_LOW;
         end
      endcase
   end

   // Outputs are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
         busy_q  <= (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
      end
   end

   assign db   = db_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected db/busy per edge come from a
// sliding window over the sampled input, plus explicit latency checks.
module tb_button_debouncer;

   localparam int SYNC = 2;
   localparam int DC   = 4;
   localparam int HLEN = SYNC + DC + 1;

   logic clk = 1'b0;
   logic reset_n;
   logic in_s;
   logic db;
   logic busy;

   always #5 clk = ~clk;

   button_debouncer #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DC),
      .CNT_WIDTH      (3)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .in     (in_s),
      .db     (db),
      .busy   (busy)
   );

   typedef struct {
      logic db;
      logic busy;
      int   edge_no;
   } exp_t;

   exp_t sb[$];
   logic hist[$];
   logic m_db;
   int   edge_cnt    = 0;
   int   vectors     = 0;
   int   miscompares = 0;

   // Window of the last HLEN sampled inputs; the FSM sees in(n-SYNC) at edge n.
   task automatic model_reset();
      hist.delete();
      repeat (HLEN) hist.push_back(1'b0);
      m_db = 1'b0;
   endtask

   task automatic drive(input logic v, input string name);
      exp_t e;
      logic all_new;
      @(negedge clk);
      in_s = v;
      hist.push_back(v);
      void'(hist.pop_front());
      all_new = 1'b1;
      for (int i = 0; i <= DC; i++)
         if (hist[i] !== ~m_db) all_new = 1'b0;
      if (all_new) m_db = ~m_db;
      e.db      = m_db;
      e.busy    = (hist[DC] !== m_db);
      e.edge_no = edge_cnt + 1;
      sb.push_back(e);
      @(posedge clk);
      edge_cnt++;
      #1;
      e = sb.pop_front();
      vectors++;
      if (db !== e.db || busy !== e.busy) begin
         miscompares++;
         $display("FAIL %s edge %0d: db=%b busy=%b, expected db=%b busy=%b",
                  name, e.edge_no, db, busy, e.db, e.busy);
      end
   endtask

   task automatic check_latency(input string name, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: change seen at edge %0d, expected edge %0d", name, got, want);
      end
   endtask

   task automatic check_idle_reset(input string name);
      vectors++;
      if (db !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: db=%b busy=%b, expected db=0 busy=0", name, db, busy);
      end
   endtask

   task automatic test_reset();
      int k;
      int rise;
      reset_n = 1'b0;
      in_s    = 1'b1;
      #2;
      check_idle_reset("reset_async");
      repeat (4) begin
         @(posedge clk);
         #1;
         check_idle_reset("reset_held");
      end
      reset_n = 1'b1;
      model_reset();
      k    = edge_cnt + 1;
      rise = -1;
      repeat (9) begin
         drive(1'b1, "reset_release");
         if (db === 1'b1 && rise < 0) rise = edge_cnt;
      end
      check_latency("reset_release_rise", rise, k + SYNC + DC);
   endtask

   task automatic test_reset_from_high();
      in_s = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_idle_reset("reset_from_high");
      @(posedge clk);
      #1;
      check_idle_reset("reset_from_high_held");
      reset_n = 1'b1;
      model_reset();
      repeat (4) drive(1'b0, "reset_from_high_idle");
   endtask

   task automatic test_clean_press();
      int k;
      int rise_db;
      int rise_busy;
      int fall_busy;
      repeat (2) drive(1'b0, "press_pre");
      k         = edge_cnt + 1;
      rise_db   = -1;
      rise_busy = -1;
      fall_busy = -1;
      repeat (10) begin
         drive(1'b1, "press");
         if (busy === 1'b1 && rise_busy < 0) rise_busy = edge_cnt;
         if (rise_busy >= 0 && busy === 1'b0 && fall_busy < 0) fall_busy = edge_cnt;
         if (db === 1'b1 && rise_db < 0) rise_db = edge_cnt;
      end
      check_latency("press_busy_rise", rise_busy, k + SYNC);
      check_latency("press_db_rise", rise_db, k + SYNC + DC);
      check_latency("press_busy_fall", fall_busy, k + SYNC + DC);
   endtask

   task automatic test_release_bounce();
      logic v[3] = '{1'b0, 1'b0, 1'b1};
      int   k;
      int   fall;
      foreach (v[i]) drive(v[i], "release_bounce");
      k    = edge_cnt + 1;
      fall = -1;
      repeat (10) begin
         drive(1'b0, "release_steady");
         if (db === 1'b0 && fall < 0) fall = edge_cnt;
      end
      check_latency("release_db_fall", fall, k + SYNC + DC);
   endtask

   task automatic test_pulse_width();
      int k;
      int rise;
      int fall;
      repeat (4) drive(1'b1, "pulse4_high");
      repeat (8) drive(1'b0, "pulse4_low");
      k    = edge_cnt + 1;
      rise = -1;
      fall = -1;
      repeat (5) begin
         drive(1'b1, "pulse5_high");
         if (db === 1'b1 && rise < 0) rise = edge_cnt;
      end
      repeat (10) begin
         drive(1'b0, "pulse5_low");
         if (db === 1'b1 && rise < 0) rise = edge_cnt;
         if (rise >= 0 && db === 1'b0 && fall < 0) fall = edge_cnt;
      end
      check_latency("pulse5_db_rise", rise, k + SYNC + DC);
      check_latency("pulse5_db_fall", fall, k + SYNC + DC + 5);
   endtask

   task automatic test_bounce_train();
      logic v[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int   k;
      int   rise;
      rise = -1;
      foreach (v[i]) begin
         drive(v[i], "bounce_train");
         if (db === 1'b1 && rise < 0) rise = edge_cnt;
      end
      k = edge_cnt;
      repeat (8) begin
         drive(1'b1, "bounce_steady");
         if (db === 1'b1 && rise < 0) rise = edge_cnt;
      end
      check_latency("bounce_db_rise", rise, k + SYNC + DC);
   endtask

   task automatic test_reset_mid_wait();
      int k;
      int rise;
      repeat (8) drive(1'b0, "midwait_idle");
      repeat (5) drive(1'b1, "midwait_count");
      vectors++;
      if (busy !== 1'b1 || db !== 1'b0) begin
         miscompares++;
         $display("FAIL midwait_busy: db=%b busy=%b, expected db=0 busy=1", db, busy);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_reset("midwait_reset_async");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_idle_reset("midwait_reset_held");
      end
      reset_n = 1'b1;
      model_reset();
      k    = edge_cnt + 1;
      rise = -1;
      repeat (9) begin
         drive(1'b1, "midwait_release");
         if (db === 1'b1 && rise < 0) rise = edge_cnt;
      end
      check_latency("midwait_db_rise", rise, k + SYNC + DC);
   endtask

   initial begin
      reset_n = 1'b0;
      in_s    = 1'b0;
      model_reset();
      test_reset();
      test_reset_from_high();
      test_clean_press();
      test_release_bounce();
      test_pulse_width();
      test_bounce_train();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
